// File: rtl/encoder_pkg.sv
// Shared types, widths and the priority-encode helper for the 8-to-3 encoder.
package encoder_pkg;

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Index of the highest set bit; returns 0 for an all-zero vector.
    function automatic logic [CODE_W-1:0] prio_encode(input logic [REQ_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < REQ_W; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // True when two or more request bits are set.
    function automatic logic is_multi(input logic [REQ_W-1:0] v);
        return ($countones(v) > 1);
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-stage flop synchronizer for asynchronous level inputs.
module sync_nff #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; synchronous clear of every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/priority_encoder_8to3.sv
// Synchronized 8-input priority encoder with capture/ack handshake and event counter.
module priority_encoder_8to3
    import encoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi,
    output logic              none,
    output logic [CNT_W-1:0]  evt_count
);

    logic [REQ_W-1:0] sreq;
    state_t           state;

    sync_nff #(
        .WIDTH  (REQ_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (sreq)
    );

    // Combinational view of the synchronized request vector.
    assign none = (sreq == '0);

    // Capture FSM: IDLE captures, HOLD waits for ack, RELEASE waits for the switch to drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= '0;
            valid     <= 1'b0;
            multi     <= 1'b0;
            evt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!none) begin
                        state <= HOLD;
                        code  <= prio_encode(sreq);
                        multi <= is_multi(sreq);
                        valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state     <= RELEASE;
                        valid     <= 1'b0;
                        multi     <= 1'b0;
                        evt_count <= evt_count + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (none) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    multi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: vector table, corner sequences, random run.
module tb_priority_encoder_8to3;
    import encoder_pkg::*;

    localparam int unsigned SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic       multi;
    logic       none;
    logic [7:0] evt_count;

    priority_encoder_8to3 #(.SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .code      (code),
        .valid     (valid),
        .multi     (multi),
        .none      (none),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;

    // Reference model: request history, "presenting" and "waiting for release" flags.
    logic [7:0] m_hist [SS];
    logic       m_presenting = 1'b0;
    logic       m_wait_low = 1'b0;
    logic [2:0] m_code = 3'd0;
    logic       m_multi = 1'b0;
    int         m_events = 0;

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        int idx;
        idx = 7;
        while (idx > 0 && v[idx] == 1'b0) idx--;
        return 3'(idx);
    endfunction

    function automatic int ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] seen;
        seen = m_hist[SS-1];
        if (!rst_n) begin
            for (int i = 0; i < int'(SS); i++) m_hist[i] = 8'h00;
            m_presenting = 1'b0;
            m_wait_low   = 1'b0;
            m_code       = 3'd0;
            m_multi      = 1'b0;
            m_events     = 0;
        end else begin
            if (m_presenting) begin
                if (ack) begin
                    m_presenting = 1'b0;
                    m_multi      = 1'b0;
                    m_wait_low   = 1'b1;
                    m_events     = m_events + 1;
                end
            end else if (m_wait_low) begin
                if (seen == 8'h00) m_wait_low = 1'b0;
            end else if (seen != 8'h00) begin
                m_presenting = 1'b1;
                m_code       = top_bit(seen);
                m_multi      = (ones(seen) >= 2);
            end
            for (int i = int'(SS) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = req;
        end
    endtask

    // One rising edge, then compare every output with the model.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("model_code",  32'(code),      32'(m_code));
        check("model_valid", 32'(valid),     32'(m_presenting));
        check("model_multi", 32'(multi),     32'(m_multi));
        check("model_none",  32'(none),      32'(m_hist[SS-1] == 8'h00));
        check("model_count", 32'(evt_count), 32'(m_events % 256));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [2:0] code;
        logic       multi;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] snap;
        vecs[0] = '{8'h08, 3'd3, 1'b0};
        vecs[1] = '{8'h81, 3'd7, 1'b1};
        vecs[2] = '{8'h24, 3'd5, 1'b1};
        vecs[3] = '{8'h01, 3'd0, 1'b0};
        vecs[4] = '{8'h80, 3'd7, 1'b0};
        vecs[5] = '{8'hFF, 3'd7, 1'b1};
        vecs[6] = '{8'h02, 3'd1, 1'b0};
        vecs[7] = '{8'h11, 3'd4, 1'b1};
        vecs[8] = '{8'h40, 3'd6, 1'b0};
        vecs[9] = '{8'h06, 3'd2, 1'b1};
        for (int i = 0; i < int'(SS); i++) m_hist[i] = 8'h00;

        // Reset state
        ticks(2);
        check("rst_code", 32'(code), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_none", 32'(none), 32'd1);
        rst_n = 1'b1;
        tick();

        // Table-driven capture/ack per vector
        for (int i = 0; i < 10; i++) begin
            check("pkg_encode", 32'(prio_encode(vecs[i].req)), 32'(vecs[i].code));
            req = vecs[i].req;
            ticks(2);
            check("latency_not_early", 32'(valid), 32'd0);
            tick();
            check("vec_valid", 32'(valid), 32'd1);
            check("vec_code", 32'(code), 32'(vecs[i].code));
            check("vec_multi", 32'(multi), 32'(vecs[i].multi));
            do_ack();
            handshakes++;
            check("vec_ack_valid", 32'(valid), 32'd0);
            check("vec_ack_multi", 32'(multi), 32'd0);
            check("vec_count", 32'(evt_count), 32'(handshakes));
            check("vec_code_kept", 32'(code), 32'(vecs[i].code));
            req = 8'h00;
            ticks(4);
        end

        // Code frozen during HOLD
        req = 8'h81;
        ticks(3);
        req = 8'h02;
        ticks(4);
        check("freeze_code", 32'(code), 32'd7);
        check("freeze_multi", 32'(multi), 32'd1);
        check("freeze_valid", 32'(valid), 32'd1);
        do_ack();
        handshakes++;
        req = 8'h00;
        ticks(4);

        // No retrigger while switch held
        req = 8'h10;
        ticks(3);
        do_ack();
        handshakes++;
        ticks(6);
        check("noretrig_valid", 32'(valid), 32'd0);
        req = 8'h00;
        ticks(4);
        req = 8'h10;
        ticks(3);
        check("retrig_valid", 32'(valid), 32'd1);
        check("retrig_code", 32'(code), 32'd4);
        do_ack();
        handshakes++;
        check("retrig_count", 32'(evt_count), 32'(handshakes));
        req = 8'h00;
        ticks(4);

        // Switch already low on ack cycle: one RELEASE cycle then recapture
        req = 8'h20;
        ticks(3);
        req = 8'h00;
        ticks(3);
        check("early_low_valid", 32'(valid), 32'd1);
        req = 8'h04;
        do_ack();
        handshakes++;
        ticks(3);
        check("early_low_recap", 32'(valid), 32'd1);
        check("early_low_code", 32'(code), 32'd2);
        do_ack();
        handshakes++;
        req = 8'h00;
        ticks(4);

        // Stray ack in IDLE
        snap = 8'(handshakes);
        ack = 1'b1;
        ticks(3);
        ack = 1'b0;
        check("stray_valid", 32'(valid), 32'd0);
        check("stray_none", 32'(none), 32'd1);
        check("stray_count", 32'(evt_count), 32'(snap));

        // Counter wrap after 256 handshakes
        for (int i = 0; i < 256; i++) begin
            req = 8'h01;
            ticks(3);
            do_ack();
            handshakes++;
            req = 8'h00;
            ticks(4);
        end
        check("wrap_count", 32'(evt_count), 32'(snap));

        // Reset mid-HOLD with simultaneous ack
        req = 8'h04;
        ticks(3);
        check("prerst_valid", 32'(valid), 32'd1);
        ack = 1'b1;
        rst_n = 1'b0;
        tick();
        ack = 1'b0;
        handshakes = 0;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_code", 32'(code), 32'd0);
        check("midrst_multi", 32'(multi), 32'd0);
        check("midrst_count", 32'(evt_count), 32'd0);
        rst_n = 1'b1;
        ticks(2);
        check("postrst_early", 32'(valid), 32'd0);
        tick();
        check("postrst_valid", 32'(valid), 32'd1);
        check("postrst_code", 32'(code), 32'd2);
        do_ack();
        req = 8'h00;
        ticks(4);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                req = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom);
            end
            ack = ($urandom_range(2) == 0);
            rst_n = ($urandom_range(249) != 0);
            tick();
        end
        rst_n = 1'b1;
        ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8to3.md
PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning number of synchronizer flops on each req line (legal 2..3).
REQ-002 Port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port req  input  8  asynchronous request lines (switches); bit i requests code i.
REQ-005 Port ack  input  1  consumer acknowledge for the presented code.
REQ-006 Port code  output  3  encoded index of highest-priority captured request.
REQ-007 Port valid  output  1  code holds an unacknowledged capture.
REQ-008 Port multi  output  1  more than one req bit was set in the capture cycle.
REQ-009 Port none  output  1  synchronized req is all-zero this cycle (combinational from sync stage).
REQ-010 Port evt_count  output  8  number of completed ack handshakes, modulo 256.

Function
REQ-011 Each req bit SHALL pass through SYNC_STAGES flops; all further logic SHALL use only the synchronized vector sreq.
REQ-012 Priority: highest set index wins (bit 7 highest); code SHALL equal that index, e.g. sreq=8'b0010_0100 -> 3'd5.
REQ-013 FSM states: IDLE, HOLD, RELEASE; reset state IDLE.
REQ-014 IDLE: if sreq!=0, next cycle SHALL enter HOLD with code, multi latched and valid=1; if sreq==0, remain IDLE, valid=0.
REQ-015 Capture latency: req change to valid=1 is SYNC_STAGES+1 rising edges.
REQ-016 HOLD: code and multi SHALL stay frozen regardless of sreq changes; valid stays 1 until ack sampled high.
REQ-017 HOLD with ack=1: next cycle valid=0, evt_count increments by 1, state -> RELEASE.
REQ-018 ack sampled while not in HOLD SHALL be ignored (no count, no state change).
REQ-019 RELEASE: remain until sreq==0 for one cycle, then -> IDLE; a held switch SHALL NOT generate a second capture.
REQ-020 If sreq is already 0 on the ack cycle, the FSM SHALL still pass through RELEASE for exactly one cycle before IDLE.
REQ-021 multi SHALL be 1 iff popcount(sreq)>=2 in the capture cycle; cleared on leaving HOLD.
REQ-022 code SHALL retain last captured value in RELEASE and IDLE (not cleared); consumers qualify with valid.
REQ-023 evt_count SHALL wrap 255 -> 0 without saturation or flag.
REQ-024 Outputs code, valid, multi, evt_count SHALL be registered; only none may be combinational.

Reset
REQ-025 With rst_n low at a rising edge: state=IDLE, code=0, valid=0, multi=0, evt_count=0, all sync flops=0.
REQ-026 Reset asserted mid-HOLD SHALL drop valid on that edge with no count increment, even if ack=1 simultaneously.
REQ-027 After rst_n deasserts, a req held high throughout reset SHALL be captured after SYNC_STAGES+1 edges.

Structure
REQ-028 Shared package encoder_pkg SHALL hold the state enum (IDLE, HOLD, RELEASE), REQ_W=8, CODE_W=3, CNT_W=8.
REQ-029 One sub-module sync_nff (width, stages parameters) SHALL implement the synchronizer; encode, FSM and counter live in the top.
REQ-030 Priority encode SHALL be a function in encoder_pkg, reused by the bench model.

Verification
REQ-031 Single request: req=8'h08 held -> valid=1, code=3, multi=0 after 3 edges (SYNC_STAGES=2); ack pulse -> valid=0, evt_count=1.
REQ-032 Multi-hot: req=8'h81 -> code=7, multi=1; change req to 8'h02 during HOLD -> code stays 7.
REQ-033 No retrigger: hold req=8'h10 across ack -> stays RELEASE, valid=0; drop req -> IDLE; raise again -> second capture, evt_count=2.
REQ-034 Stray ack: ack=1 in IDLE with req=0 -> valid=0, evt_count unchanged, none=1.
REQ-035 Wrap: 256 capture/ack cycles -> evt_count returns to 0.
REQ-036 Reset mid-HOLD with ack=1 same cycle -> all outputs 0, evt_count=0; req still high -> recapture 3 edges after reset release.
